// File: rtl/memory_access_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the data memory (slave).
interface memory_access_if #(
   parameter int ADDR_W    = 32,
   parameter int DATA_SIZE = 32
);
   logic                 req;
   logic                 we;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_SIZE-1:0] wdata;
   logic [DATA_SIZE-1:0] rdata;
   logic                 ready;

   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: issues lw/sw over the dmem bus, stalls upstream, feeds MEM_WB_*.
// Optional MEM_PERF_EN macro adds load/store/stall performance counters.
//
// state  | meaning
// IDLE   | no access outstanding; pass-through, misalign check, or issue a request
// WAIT   | request outstanding; waiting for dmem ready or timeout
module memory_access #(
   parameter int ADDR_W      = 32,
   parameter int DATA_SIZE   = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [DATA_SIZE-1:0] EX_MEM_result,
   input  logic [DATA_SIZE-1:0] EX_MEM_store_data,
   input  logic [4:0]           EX_MEM_dest,
   input  logic [5:0]           EX_MEM_op,
   input  logic [1:0]           EX_MEM_instruc_type,
   output logic                 MEM_stall,
   memory_access_if.master      dmem,
   output logic [DATA_SIZE-1:0] MEM_WB_result,
   output logic [DATA_SIZE-1:0] MEM_WB_data,
   output logic [4:0]           MEM_WB_dest,
   output logic [5:0]           MEM_WB_op,
   output logic [1:0]           MEM_WB_instruc_type,
   output logic                 MEM_exc
`ifdef MEM_PERF_EN
   ,
   output logic [31:0]          perf_loads,
   output logic [31:0]          perf_stores,
   output logic [31:0]          perf_stall_cycles
`endif
);

   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam bit TO_EN   = (TIMEOUT_CYC > 0);
   localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam int CNT_W   = $clog2(TIMEOUT_CYC + 2);

   logic [0:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic                 is_lw;
   logic                 is_sw;
   logic                 is_mem;
   logic                 mis;
   logic                 timeout_hit;
   logic                 wb_pass;
   logic [DATA_SIZE-1:0] wb_data;

   always_comb begin
      is_lw       = (EX_MEM_op == OP_LW);
      is_sw       = (EX_MEM_op == OP_SW);
      is_mem      = is_lw || is_sw;
      mis         = is_mem && (EX_MEM_result[1:0] != 2'b00);
      // Abort lands on the TIMEOUT_CYC-th WAIT cycle; the counter is 0 on the first one.
      timeout_hit = TO_EN && (state == S_WAIT) && !dmem.ready && (cnt == CNT_W'(TO_LAST));
      if (state == S_IDLE)
         MEM_stall = is_mem && !mis;
      else
         MEM_stall = !dmem.ready && !timeout_hit;
      wb_pass     = ((state == S_IDLE) && !is_mem) || ((state == S_WAIT) && dmem.ready);
      wb_data     = ((state == S_WAIT) && is_lw) ? dmem.rdata : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         dmem.req   <= 1'b0;
         dmem.we    <= 1'b0;
         dmem.addr  <= '0;
         dmem.wdata <= '0;
         MEM_exc    <= 1'b0;
      end else begin
         MEM_exc <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (is_mem && !mis) begin
                  dmem.req   <= 1'b1;
                  dmem.we    <= is_sw;
                  dmem.addr  <= EX_MEM_result[ADDR_W-1:0];
                  dmem.wdata <= EX_MEM_store_data;
                  state      <= S_WAIT;
               end else if (mis) begin
                  MEM_exc <= 1'b1;
               end
            end
            default: begin
               if (dmem.ready) begin
                  dmem.req <= 1'b0;
                  state    <= S_IDLE;
               end else if (timeout_hit) begin
                  dmem.req <= 1'b0;
                  MEM_exc  <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Anything that is not a pass-through retires as an all-zero bubble.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         MEM_WB_result       <= '0;
         MEM_WB_data         <= '0;
         MEM_WB_dest         <= '0;
         MEM_WB_op           <= '0;
         MEM_WB_instruc_type <= '0;
      end else if (wb_pass) begin
         MEM_WB_result       <= EX_MEM_result;
         MEM_WB_data         <= wb_data;
         MEM_WB_dest         <= EX_MEM_dest;
         MEM_WB_op           <= EX_MEM_op;
         MEM_WB_instruc_type <= EX_MEM_instruc_type;
      end else begin
         MEM_WB_result       <= '0;
         MEM_WB_data         <= '0;
         MEM_WB_dest         <= '0;
         MEM_WB_op           <= '0;
         MEM_WB_instruc_type <= '0;
      end
   end

`ifdef MEM_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_loads        <= '0;
         perf_stores       <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if ((state == S_WAIT) && dmem.ready && is_lw)
            perf_loads <= perf_loads + 32'd1;
         if ((state == S_WAIT) && dmem.ready && is_sw)
            perf_stores <= perf_stores + 32'd1;
         if (MEM_stall)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus a randomized instruction stream.
module tb_memory_access;

   localparam int T = 4;
   localparam logic [5:0] LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] EX_MEM_result;
   logic [31:0] EX_MEM_store_data;
   logic [4:0]  EX_MEM_dest;
   logic [5:0]  EX_MEM_op;
   logic [1:0]  EX_MEM_instruc_type;
   logic        MEM_stall;
   logic [31:0] MEM_WB_result;
   logic [31:0] MEM_WB_data;
   logic [4:0]  MEM_WB_dest;
   logic [5:0]  MEM_WB_op;
   logic [1:0]  MEM_WB_instruc_type;
   logic        MEM_exc;

   int checks = 0;
   int errors = 0;

   memory_access_if #(.ADDR_W(32), .DATA_SIZE(32)) dmem ();

   memory_access #(.ADDR_W(32), .DATA_SIZE(32), .TIMEOUT_CYC(T)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .EX_MEM_result       (EX_MEM_result),
      .EX_MEM_store_data   (EX_MEM_store_data),
      .EX_MEM_dest         (EX_MEM_dest),
      .EX_MEM_op           (EX_MEM_op),
      .EX_MEM_instruc_type (EX_MEM_instruc_type),
      .MEM_stall           (MEM_stall),
      .dmem                (dmem),
      .MEM_WB_result       (MEM_WB_result),
      .MEM_WB_data         (MEM_WB_data),
      .MEM_WB_dest         (MEM_WB_dest),
      .MEM_WB_op           (MEM_WB_op),
      .MEM_WB_instruc_type (MEM_WB_instruc_type),
      .MEM_exc             (MEM_exc)
   );

   always #5 clock = ~clock;

   // Reference behaviour of one instruction, derived from the pipeline rules:
   // non-mem/misaligned retire in 1 cycle without stall; an aligned access stalls
   // for the issue cycle plus every WAIT cycle that sees no ready, and either completes
   // on the first ready or is aborted on WAIT cycle T.
   task automatic run_instr(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sdata,
                            input logic [4:0] dest, input logic [1:0] typ, input int wait_n,
                            input logic [31:0] rd, input string tag);
      bit is_mem = (op == LW) || (op == SW);
      bit mis    = is_mem && (res[1:0] != 2'b00);
      bit done;
      bit aborted;
      @(negedge clock);
      EX_MEM_op = op; EX_MEM_result = res; EX_MEM_store_data = sdata;
      EX_MEM_dest = dest; EX_MEM_instruc_type = typ;
      dmem.ready = 1'($urandom_range(0, 1));
      dmem.rdata = $urandom;
      #1;
      checks++;
      if (MEM_stall !== (is_mem && !mis)) begin
         errors++; $display("FAIL %s issue_stall: got %b expected %b", tag, MEM_stall, is_mem && !mis);
      end
      @(posedge clock); #1;
      if (!is_mem) begin
         checks++;
         if ({MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type, MEM_exc, dmem.req}
             !== {res, 32'h0, dest, op, typ, 1'b0, 1'b0}) begin
            errors++; $display("FAIL %s passthru: got res=%h data=%h dest=%0d op=%h typ=%b exc=%b req=%b expected res=%h data=0 dest=%0d op=%h typ=%b exc=0 req=0",
               tag, MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type, MEM_exc, dmem.req,
               res, dest, op, typ);
         end
         return;
      end
      if (mis) begin
         checks++;
         if ({MEM_WB_instruc_type, MEM_exc, dmem.req} !== {2'b00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL %s misalign: got typ=%b exc=%b req=%b expected typ=00 exc=1 req=0",
               tag, MEM_WB_instruc_type, MEM_exc, dmem.req);
         end
         return;
      end
      checks++;
      if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, MEM_WB_instruc_type, MEM_exc}
          !== {1'b1, op == SW, res, sdata, 2'b00, 1'b0}) begin
         errors++; $display("FAIL %s issue: got req=%b we=%b addr=%h wdata=%h typ=%b exc=%b expected req=1 we=%b addr=%h wdata=%h typ=00 exc=0",
            tag, dmem.req, dmem.we, dmem.addr, dmem.wdata, MEM_WB_instruc_type, MEM_exc, op == SW, res, sdata);
      end
      for (int k = 1; k <= T; k++) begin
         @(negedge clock);
         done    = (k > wait_n);
         aborted = !done && (k == T);
         dmem.ready = done;
         dmem.rdata = done ? rd : $urandom;
         #1;
         checks++;
         if (MEM_stall !== !(done || aborted)) begin
            errors++; $display("FAIL %s wait%0d_stall: got %b expected %b", tag, k, MEM_stall, !(done || aborted));
         end
         @(posedge clock); #1;
         if (done) begin
            checks++;
            if ({dmem.req, MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type, MEM_exc}
                !== {1'b0, res, (op == LW) ? rd : 32'h0, dest, op, typ, 1'b0}) begin
               errors++; $display("FAIL %s complete: got req=%b res=%h data=%h dest=%0d op=%h typ=%b exc=%b expected req=0 res=%h data=%h dest=%0d op=%h typ=%b exc=0",
                  tag, dmem.req, MEM_WB_result, MEM_WB_data, MEM_WB_dest, MEM_WB_op, MEM_WB_instruc_type, MEM_exc,
                  res, (op == LW) ? rd : 32'h0, dest, op, typ);
            end
         end else if (aborted) begin
            checks++;
            if ({dmem.req, MEM_WB_instruc_type, MEM_exc} !== {1'b0, 2'b00, 1'b1}) begin
               errors++; $display("FAIL %s timeout: got req=%b typ=%b exc=%b expected req=0 typ=00 exc=1",
                  tag, dmem.req, MEM_WB_instruc_type, MEM_exc);
            end
         end else begin
            checks++;
            if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, MEM_WB_instruc_type, MEM_exc}
                !== {1'b1, op == SW, res, sdata, 2'b00, 1'b0}) begin
               errors++; $display("FAIL %s hold%0d: got req=%b we=%b addr=%h wdata=%h typ=%b exc=%b expected req=1 we=%b addr=%h wdata=%h typ=00 exc=0",
                  tag, k, dmem.req, dmem.we, dmem.addr, dmem.wdata, MEM_WB_instruc_type, MEM_exc, op == SW, res, sdata);
            end
         end
         if (done || aborted) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      EX_MEM_op = 6'h00; EX_MEM_result = '0; EX_MEM_store_data = '0;
      EX_MEM_dest = '0; EX_MEM_instruc_type = '0;
      dmem.ready = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
      #22;
      checks++;
      if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, MEM_WB_result, MEM_WB_data, MEM_WB_dest,
           MEM_WB_op, MEM_WB_instruc_type, MEM_exc} !== '0) begin
         errors++; $display("FAIL reset_values: got req=%b we=%b addr=%h wdata=%h res=%h data=%h typ=%b exc=%b expected all 0",
            dmem.req, dmem.we, dmem.addr, dmem.wdata, MEM_WB_result, MEM_WB_data, MEM_WB_instruc_type, MEM_exc);
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_alu();
      run_instr(6'h00, 32'h10, 32'h0, 5'd3, 2'b10, 0, 32'h0, "alu_add");
   endtask

   task automatic test_load_zero_wait();
      run_instr(LW, 32'h100, 32'h0, 5'd7, 2'b10, 0, 32'hDEADBEEF, "lw_zero_wait");
   endtask

   task automatic test_store_wait();
      run_instr(SW, 32'h24, 32'h55, 5'd0, 2'b01, 3, 32'h0, "sw_wait3");
   endtask

   task automatic test_misalign();
      run_instr(LW, 32'h102, 32'h0, 5'd4, 2'b10, 0, 32'h0, "lw_misalign");
      run_instr(SW, 32'h201, 32'h9, 5'd0, 2'b01, 0, 32'h0, "sw_misalign");
   endtask

   task automatic test_timeout();
      run_instr(LW, 32'h80, 32'h0, 5'd9, 2'b10, 100, 32'h0, "lw_timeout");
      run_instr(6'h08, 32'h33, 32'h0, 5'd2, 2'b10, 0, 32'h0, "after_timeout");
   endtask

   task automatic test_back_to_back();
      run_instr(LW, 32'h40, 32'h0, 5'd5, 2'b10, 0, 32'h1234_5678, "b2b_lw");
      run_instr(SW, 32'h44, 32'hCAFE, 5'd0, 2'b01, 1, 32'h0, "b2b_sw");
      run_instr(LW, 32'h48, 32'h0, 5'd6, 2'b10, 2, 32'hA5A5_0F0F, "b2b_lw2");
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clock);
      EX_MEM_op = LW; EX_MEM_result = 32'h60; EX_MEM_dest = 5'd8; EX_MEM_instruc_type = 2'b10;
      dmem.ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({dmem.req, dmem.addr, MEM_WB_result, MEM_WB_instruc_type, MEM_exc} !== '0) begin
         errors++; $display("FAIL reset_mid_wait: got req=%b addr=%h res=%h typ=%b exc=%b expected all 0",
            dmem.req, dmem.addr, MEM_WB_result, MEM_WB_instruc_type, MEM_exc);
      end
      @(negedge clock);
      reset_n = 1'b1;
      EX_MEM_op = 6'h00; EX_MEM_result = 32'h77; EX_MEM_dest = 5'd1; EX_MEM_instruc_type = 2'b10;
      dmem.ready = 1'b1; dmem.rdata = 32'hBAD0_BAD0;
      #1;
      checks++;
      if (MEM_stall !== 1'b0) begin
         errors++; $display("FAIL post_reset_stall: got %b expected 0", MEM_stall);
      end
      @(posedge clock); #1;
      checks++;
      if ({dmem.req, MEM_WB_result, MEM_WB_data, MEM_WB_instruc_type} !== {1'b0, 32'h77, 32'h0, 2'b10}) begin
         errors++; $display("FAIL post_reset_idle: got req=%b res=%h data=%h typ=%b expected req=0 res=00000077 data=0 typ=10",
            dmem.req, MEM_WB_result, MEM_WB_data, MEM_WB_instruc_type);
      end
   endtask

   task automatic test_random();
      logic [5:0] alu_ops [5];
      logic [5:0] op;
      logic [31:0] res;
      int kind;
      alu_ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F};
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 5);
         res  = $urandom;
         case (kind)
            0, 1:    op = alu_ops[$urandom_range(0, 4)];
            2, 3:    op = LW;
            default: op = SW;
         endcase
         if (op == LW || op == SW) begin
            if ($urandom_range(0, 4) != 0) res[1:0] = 2'b00;
         end
         run_instr(op, res, $urandom, 5'($urandom), 2'($urandom), $urandom_range(0, 6), $urandom,
                   $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_zero_wait();
      test_store_wait();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_mid_wait();
      test_random();
      run_instr(6'h00, 32'h0, 32'h0, 5'd0, 2'b00, 0, 32'h0, "final_nop");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
